// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit owning HI/LO. Optional MADD/MSUB family under `MDU_MADD_EN.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; HI/LO update on the cycle busy falls. MTHI/MTLO take 1 cycle.
// Backpressure: busy drives the hazard-unit stall; any start seen while busy is dropped.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_LD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LD  = 5'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [63:0] pend, pend_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
  assign a_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag = b[31] ? (~b + 32'd1) : b;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = a / b;
  assign r_u   = a % b;

  assign busy = (state == BUSY);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            4'd1: begin pend_nxt = prod_s; cnt_nxt = MULT_LD; state_nxt = BUSY; end
            4'd2: begin pend_nxt = prod_u; cnt_nxt = MULT_LD; state_nxt = BUSY; end
            4'd3: begin
              pend_nxt  = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {r_s, q_s};
              cnt_nxt   = DIV_LD;
              state_nxt = BUSY;
            end
            4'd4: begin
              pend_nxt  = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {r_u, q_u};
              cnt_nxt   = DIV_LD;
              state_nxt = BUSY;
            end
            4'd5: hi_nxt = a;
            4'd6: lo_nxt = a;
`ifdef MDU_MADD_EN
            4'd7:  begin pend_nxt = {hi, lo} + prod_s; cnt_nxt = MULT_LD; state_nxt = BUSY; end
            4'd8:  begin pend_nxt = {hi, lo} + prod_u; cnt_nxt = MULT_LD; state_nxt = BUSY; end
            4'd9:  begin pend_nxt = {hi, lo} - prod_s; cnt_nxt = MULT_LD; state_nxt = BUSY; end
            4'd10: begin pend_nxt = {hi, lo} - prod_u; cnt_nxt = MULT_LD; state_nxt = BUSY; end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt == 5'd0) begin
          {hi_nxt, lo_nxt} = pend;
          state_nxt        = IDLE;
        end else begin
          cnt_nxt = cnt - 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      pend  <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: scoreboarded ops with busy-length, HI/LO, ignore, async reset and MADD checks.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_hi, m_lo;

  ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, m;
    longint unsigned ux, uy, uq, um;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = 64'd0;
    case (o)
      4'd1: r = sx * sy;
      4'd2: r = ux * uy;
      4'd3: if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else begin q = sx / sy; m = sx % sy; r = {m[31:0], q[31:0]}; end
      4'd4: if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else begin uq = ux / uy; um = ux % uy; r = {um[31:0], uq[31:0]}; end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Issue a multi-cycle op; optionally pulse MTHI during busy cycle inj.
  task automatic run_op(input logic [3:0] o, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] eh, input logic [31:0] el, input int lat,
                        input int inj, input string nm);
    exp_t e;
    int   cnt;
    bit   done;
    @(negedge clk);
    start = 1'b1; op = o; a = oa; b = ob;
    e.hi = eh; e.lo = el; e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    cnt = 0; done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (busy === 1'b1) cnt++;
      else done = 1'b1;
      if (!done && k == inj) begin start = 1'b1; op = 4'd5; a = 32'h1234; end
      else begin start = 1'b0; op = 4'd0; end
      if (!done) @(negedge clk);
    end
    e = sb.pop_front();
    n_vec++;
    if (!done) begin n_err++; $display("FAIL %s timeout: busy still %b after 40 cycles", nm, busy); end
    n_vec++;
    if (cnt != e.lat) begin n_err++; $display("FAIL %s busy_len: got %0d want %0d", nm, cnt, e.lat); end
    n_vec++;
    if (hi !== e.hi) begin n_err++; $display("FAIL %s hi: got %h want %h", nm, hi, e.hi); end
    n_vec++;
    if (lo !== e.lo) begin n_err++; $display("FAIL %s lo: got %h want %h", nm, lo, e.lo); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic do_mt(input logic [3:0] o, input logic [31:0] val);
    @(negedge clk);
    start = 1'b1; op = o; a = val;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    if (o == 4'd5) m_hi = val; else m_lo = val;
    n_vec++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++;
      $display("FAIL mt%0d: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", o, busy, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    #12;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
    n_vec++;
    if (hi !== 32'd0) begin n_err++; $display("FAIL reset hi: got %h want 0", hi); end
    n_vec++;
    if (lo !== 32'd0) begin n_err++; $display("FAIL reset lo: got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_mult;
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 0, "mult");
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 0, "multu");
  endtask

  task automatic test_div;
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0, "div_neg");
    run_op(4'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10, 0, "divu_by0");
    run_op(4'd3, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 10, 0, "div_by0");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0, "div_ovf");
  endtask

  task automatic test_busy_ignore;
    run_op(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 3, "div_ignore");
  endtask

  task automatic test_nop;
    do_mt(4'd5, 32'hCAFE_0001);
    do_mt(4'd6, 32'hBEEF_0002);
    @(negedge clk);
    start = 1'b1; op = 4'd0; a = 32'h1111; b = 32'h2222;
    @(negedge clk);
    op = 4'd15;
    @(negedge clk);
    start = 1'b0; op = 4'd1;
    n_vec++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL nop: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL start0: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    end
    op = 4'd0;
  endtask

  task automatic test_random;
    logic [3:0]  o;
    logic [31:0] x, y;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      o = 4'($urandom_range(1, 4));
      x = $urandom;
      y = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      if (i == 0) y = 32'hFFFF_FFFF;
      r = ref_res(o, x, y);
      run_op(o, x, y, r[63:32], r[31:0], (o <= 4'd2) ? 5 : 10, 0, "rand");
    end
  endtask

  task automatic test_madd;
    do_mt(4'd5, 32'd0);
    do_mt(4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op(4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0, "maddu");
`else
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 4'd8; a = 32'd1; b = 32'd1;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      for (int k = 0; k < 8; k++) begin
        if (busy !== 1'b0) seen = 1'b1;
        @(negedge clk);
      end
      n_vec++;
      if (seen) begin n_err++; $display("FAIL maddu_off busy: asserted, want never"); end
      n_vec++;
      if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
        n_err++; $display("FAIL maddu_off hilo: got %h_%h want 00000000_ffffffff", hi, lo);
      end
    end
`endif
  endtask

  task automatic test_async_reset;
    do_mt(4'd5, 32'hAAAA_AAAA);
    do_mt(4'd6, 32'h5555_5555);
    @(negedge clk);
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL async_reset: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL late_commit: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_busy_ignore();
    test_nop();
    test_random();
    test_madd();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes EX_RD1/EX_RD2 operands and a decoded MDU opcode.
- Runs mult/div with fixed multi-cycle latency and owns the architectural HI/LO registers.
- Exposes busy to the hazard unit so that MDU instructions in ID stall while an operation is in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD family); legal range 1..31
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..31

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  op valid this cycle (EX instr is an MDU op, not flushed)
op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; others NOP
a  in  32  rs operand (forwarded EX_RD1)
b  in  32  rt operand (forwarded EX_RD2)
busy  out  1  operation in flight
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (asynchronous, low): busy=0, hi=0, lo=0, counter=0, pending results=0, FSM=IDLE. Immediate effect, including mid-operation; the in-flight op is discarded.
- FSM has two states, IDLE and BUSY.
- IDLE, start=1, op in MULT..DIVU (or MADD family when enabled), at edge t0:
  - Capture operands.
  - Compute the 64-bit pending result.
  - Load counter = LAT-1.
  - Go to BUSY.
- BUSY: busy=1 for exactly LAT cycles (t0+1 .. t0+LAT).
  - Counter decrements each edge.
  - At the edge where counter==0: hi/lo <= pending, then go to IDLE.
  - New hi/lo values are visible from cycle t0+LAT+1, the same cycle busy reads 0.
- start while BUSY: ignored entirely. No restart, no MTHI/MTLO effect. The hazard unit guarantees this does not occur; the bench checks that it is ignored.
- MTHI/MTLO in IDLE: hi<=a (or lo<=a) at the edge, single cycle, busy stays 0.
- MFHI/MFLO: a read of the hi/lo outputs by EX muxing, not an op here. The hazard unit must stall them while busy or while start carries a multi-cycle op.
- MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0]. MULTU: unsigned.
- DIV: lo = signed quotient, truncated toward zero; hi = remainder, same sign as dividend.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b==0), both DIV and DIVU: lo = 32'hFFFF_FFFF, hi = a. Latency is still DIV_CYCLES.
- Signed overflow, DIV 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0.
- NOP or undefined op with start=1: no state change.
- start=0: no state change regardless of op.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: ops 7..10 are legal with MULT_CYCLES latency, computed with 64-bit wraparound:
  - MADD: {hi,lo} += signed a*b
  - MADDU: {hi,lo} += unsigned a*b
  - MSUB: {hi,lo} -= signed a*b
  - MSUBU: {hi,lo} -= unsigned a*b
  - The {hi,lo} used is the value sampled at t0.
- Not defined: ops 7..10 decode as NOP; no accumulator adder is synthesized.

Test Plan:
1. Reset low, then high; start=1, op=MULT, a=0xFFFFFFFF, b=2 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same stimulus with op=MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
2. op=DIV, a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. op=DIVU, a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
3. op=DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, no X.
4. Start DIV; at busy cycle 3 pulse start with op=MTHI, a=0x1234 -> ignored; final hi/lo equal the DIV result; busy still falls after exactly 10 cycles.
5. Start MULT; assert reset low asynchronously mid-cycle during busy cycle 2 -> busy, hi, lo drop to 0 immediately, without waiting for a clock edge; after release, no late commit occurs.
6. MDU_MADD_EN defined: MTHI 0, MTLO 0xFFFFFFFF, then MADDU a=1, b=1 -> hi=1, lo=0. Macro undefined, same sequence -> hi=0, lo=0xFFFFFFFF, busy never asserted.
